// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants for the front-end pipeline stages.
package cpu_pkg;

  localparam int unsigned     XLEN     = 32;
  localparam int unsigned     INSN_W   = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0]     INSN_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer between instruction memory and decode; flush beats push/pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned    AW   = $clog2(DEPTH);
  localparam logic [AW:0]    FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;

  always_comb begin
    do_pop    = pop && (count != '0);
    do_push   = push && ((count != FULL) || do_pop);
    head_data = mem[rd_ptr];
  end

  // Storage is reset so the head reads as zero out of reset rather than X.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues credit-limited requests
// to 1-cycle instruction memory and buffers responses for decode.
module fetch_unit #(
  parameter int unsigned     XLEN     = cpu_pkg::XLEN,
  parameter int unsigned     INSN_W   = cpu_pkg::INSN_W,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(cpu_pkg::RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [INSN_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INSN_W-1:0] out_insn,
  output logic [XLEN-1:0]   out_pc
);

  localparam int unsigned CW     = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDIT = (CW+1)'(DEPTH);

  logic [XLEN-1:0]        fpc;
  logic                   inflight;
  logic [XLEN-1:0]        inflight_pc;
  logic [CW-1:0]          count;
  logic [CW:0]            used;
  logic                   push;
  logic                   pop;
  logic [XLEN+INSN_W-1:0] head;

  // A slot is reserved for every in-flight read, so a response can never overflow.
  always_comb begin
    used      = {1'b0, count} + {{CW{1'b0}}, inflight};
    imem_req  = reset && !redirect_valid && (used < CREDIT);
    imem_addr = fpc;
    push      = inflight && !redirect_valid;
    out_valid = (count != '0);
    pop       = out_valid && out_ready;
    {out_pc, out_insn} = head;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc         <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fpc      <= {redirect_pc[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fpc         <= fpc + XLEN'(4);
        inflight_pc <= fpc;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (XLEN + INSN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({inflight_pc, imem_rdata}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (head),
    .count     (count)
  );

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decode/register-file/control path.
- Owns the fetch PC and issues sequential word-aligned requests to the synchronous instruction memory (fixed 1-cycle read latency).
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts branch/jump redirects, which flush all buffered and in-flight fetches.

Parameters:
- XLEN, 32, fetch PC / address width.
- INSN_W, 32, instruction width.
- DEPTH, 4, prefetch FIFO entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- imem_req  output  1  read request to instruction memory this cycle.
- imem_addr  output  XLEN  byte address of request; bits [1:0] always 0.
- imem_rdata  input  INSN_W  read data; valid the cycle after an accepted request.
- redirect_valid  input  1  taken branch/jump from downstream.
- redirect_pc  input  XLEN  redirect target.
- out_valid  output  1  out_insn/out_pc hold a valid instruction.
- out_ready  input  1  decode accepts the head entry.
- out_insn  output  INSN_W  instruction at FIFO head.
- out_pc  output  XLEN  PC of out_insn.

Behaviour:
- Reset (asynchronous assert, synchronous-release use):
  - imem_req=0, imem_addr=RESET_PC, out_valid=0, out_insn=0, out_pc=0.
  - FIFO empty, in-flight flag cleared, fpc=RESET_PC.
- Internal state:
  - fpc (next fetch address).
  - inflight (1 bit) and inflight_pc.
  - FIFO of {pc, insn}, with rd/wr pointers mod DEPTH and count 0..DEPTH.
- Request rule: imem_req=1 iff redirect_valid=0 and (count + inflight) < DEPTH.
  - imem_addr=fpc.
  - On request: fpc <= fpc+4, modulo 2^XLEN (wraps 0xFFFF_FFFC -> 0), and inflight <= 1 with inflight_pc <= fpc.
  - Otherwise inflight <= 0.
- Response: if inflight=1 and no redirect this cycle, push {inflight_pc, imem_rdata} at the end of the cycle.
  - The credit rule guarantees no overflow.
- Latency: request in cycle N, rdata during N+1, out_valid=1 in N+2. No bypass from imem_rdata to outputs.
- Throughput: with out_ready held 1, one instruction per cycle in steady state.
- Handshake:
  - Pop when out_valid & out_ready.
  - out_insn/out_pc stay stable while out_valid=1 & out_ready=0.
  - out_valid = (count != 0).
  - out_insn/out_pc are don't-care when out_valid=0 but are driven from the head register, not X.
- Simultaneous push and pop: both take effect, count unchanged. Pop when empty is ignored.
- Redirect (highest priority):
  - Cycle with redirect_valid=1: FIFO cleared, any pop that cycle discarded, in-flight response dropped, imem_req=0.
  - fpc <= {redirect_pc[XLEN-1:2], 2'b00} (misaligned targets truncated).
  - Next cycle: out_valid=0 and request at the new fpc.
  - Back-to-back redirects: the last one wins; no request is issued while redirect_valid=1.
- Redirect in the same cycle as out_valid & out_ready: decode sees the handshake, but the block treats the FIFO as flushed. Decode owns squashing that instruction.
- Reset mid-operation: immediate return to reset values. Any in-flight response is never pushed.

Decomposition:
- Shared package cpu_pkg: XLEN, INSN_W, RESET_PC, INSN_NOP = 32'h0000_0013.
- Sub-module fetch_fifo: synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: clk, reset, push, push_data, pop, flush, head_data, count.
  - flush has priority over push and pop.
- fetch_unit contains the fpc, request/credit logic, in-flight tracking and redirect control.

Test Plan:
1. Release reset, memory returns addr^32'hA5A5_0000, out_ready=1 -> imem_addr 0,4,8,... on consecutive cycles; first out_valid 2 cycles after the first req with out_pc=0, out_insn=32'hA5A5_0000; then one instruction per cycle.
2. out_ready=0 from reset -> exactly 4 requests (0,4,8,C), imem_req=0 afterwards, out_pc held at 0; raise out_ready -> outputs 0,4,8,C in order, then fetching resumes at 0x10.
3. Redirect to 0x100 while FIFO holds 3 entries and one fetch is in flight -> next cycle out_valid=0 and imem_addr=0x100; next valid out_pc=0x100; none of the stale PCs ever appear.
4. redirect_pc=0x0000_0206 -> fetch resumes at 0x204; set fpc to 0xFFFF_FFFC via redirect -> next request addresses are 0xFFFF_FFFC then 0x0000_0000.
5. Assert reset low mid-stream with 2 entries buffered -> outputs go to reset values immediately; after release the first request is RESET_PC and no pre-reset data appears.
6. Random out_ready toggling over 1000 cycles against a reference model -> out_pc strictly sequential between redirects, no loss or duplication, count never exceeds 4.
